branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Parametrised branch-target predictor for the 5-stage pipeline. Today, branches resolve in MEM and there is no prediction; this block replaces that behaviour.
- IF looks up the current PC and receives a predicted next PC in the same cycle.
- MEM reports each resolved branch/jump. The block trains a direct-mapped BTB with saturating counters and keeps prediction/misprediction statistics.

Parameters:
- PC_WIDTH, 32, width of PC and target.
- ENTRIES, 16, number of BTB entries; power of two, ≥2. INDEX_BITS = log2(ENTRIES).
- COUNTER_BITS, 2, width of the saturating direction counter; ≥1.
- STAT_WIDTH, 32, width of the statistics counters.

Ports:
- clock  in  1  single rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- lookupPc  in  PC_WIDTH  PC being fetched in IF.
- predictTaken  out  1  lookup hit and counter MSB = 1.
- predictedPc  out  PC_WIDTH  stored target if predictTaken, else lookupPc+4 (modulo 2^PC_WIDTH).
- updateValid  in  1  one resolved control-flow instruction from MEM this cycle.
- updatePc  in  PC_WIDTH  PC of the resolved instruction.
- updateTaken  in  1  actual outcome.
- updateTarget  in  PC_WIDTH  actual target (meaningful when taken).
- updateWasPredictedTaken  in  1  predictTaken value carried down the pipe for this instruction.
- flush  in  1  synchronous invalidate-all.
- predictionCount  out  STAT_WIDTH  number of accepted updates.
- mispredictionCount  out  STAT_WIDTH  number of accepted updates that were mispredicted.

Behaviour:
- Addressing:
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[PC_WIDTH-1:INDEX_BITS+2].
  - pc[1:0] is ignored.
- Entry state: valid, tag, target, counter.
- Lookup is purely combinational from registered state; latency is 0 cycles.
  - hit = valid[index] && tag match.
  - predictTaken = hit && counter[COUNTER_BITS-1].
- Reset (asynchronous assert, on reset=0):
  - all valid=0, tags=0, targets=0.
  - counters = WEAK_NT = 2^(COUNTER_BITS-1)-1 (01 for 2 bits).
  - both statistics counters = 0.
  - Resulting outputs: predictTaken=0, predictedPc=lookupPc+4.
  - Deassertion is taken synchronously (registers are released on the first clock edge after reset=1).
- Update, on the rising edge when updateValid=1:
  - Hit and taken: counter+1, saturating at all-ones; target overwritten with updateTarget.
  - Hit and not taken: counter-1, saturating at 0; target unchanged.
  - Miss and taken: allocate/replace the entry. valid=1, new tag, target = updateTarget, counter = WEAK_T = 2^(COUNTER_BITS-1) (10 for 2 bits). An aliasing entry is evicted.
  - Miss and not taken: no state change.
  - predictionCount += 1.
  - mispredictionCount += 1 when (updateTaken != updateWasPredictedTaken), or when (updateTaken && updateWasPredictedTaken && stored target before the update != updateTarget, on a hit).
  - Statistics counters wrap modulo 2^STAT_WIDTH.
- Same-cycle lookup and update of the same index: lookup returns the pre-update state; the new state is visible the following cycle.
- flush=1 on a rising edge:
  - clears all valid bits.
  - counters, targets and statistics are untouched.
  - If updateValid is also 1, flush wins for valid bits; the statistics still count the update; no allocation occurs.
- Update while reset is asserted: ignored.
- Reset asserted in the middle of a stream: state returns to reset values immediately, no clock required.
- COUNTER_BITS=1: WEAK_NT=0, WEAK_T=1.

Test Plan:
- Reset then lookupPc=0x40 -> predictTaken=0, predictedPc=0x44, both statistics counters = 0.
- Update pc=0x40, taken, target=0x100, wasPredicted=0; next cycle lookup 0x40 -> predictTaken=1, predictedPc=0x100, predictionCount=1, mispredictionCount=1.
- Two not-taken updates to 0x40 -> counter 10→01→00; lookup gives predictTaken=0. Three taken updates -> counter saturates at 11; a fourth taken update leaves it at 11.
- Alias test (ENTRIES=16):
  - Allocate 0x40 → target 0x100.
  - Update 0x440 taken → target 0x200.
  - Lookup 0x40 -> predictedPc=0x44 (evicted).
  - Lookup 0x440 -> predictedPc=0x200.
- Same-cycle update and lookup of 0x40 -> lookup shows old prediction, new one the next cycle. Then flush -> lookup 0x40 gives 0x44 while the statistics are retained.
- Reset pulled low mid-stream with counters nonzero -> outputs and statistics return to reset values without a clock edge. Separately, drive 2^STAT_WIDTH updates with STAT_WIDTH=4 -> predictionCount wraps to 0.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// The IF lookup is combinational (0 cycles); MEM training and statistics update on the clock edge.
module branch_target_predictor #(
    parameter int PC_WIDTH     = 32,
    parameter int ENTRIES      = 16,
    parameter int COUNTER_BITS = 2,
    parameter int STAT_WIDTH   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   lookupPc,
    output logic                  predictTaken,
    output logic [PC_WIDTH-1:0]   predictedPc,
    input  logic                  updateValid,
    input  logic [PC_WIDTH-1:0]   updatePc,
    input  logic                  updateTaken,
    input  logic [PC_WIDTH-1:0]   updateTarget,
    input  logic                  updateWasPredictedTaken,
    input  logic                  flush,
    output logic [STAT_WIDTH-1:0] predictionCount,
    output logic [STAT_WIDTH-1:0] mispredictionCount
);

    localparam int INDEX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS   = PC_WIDTH - INDEX_BITS - 2;

    localparam int WEAK_NT_INT = (1 << (COUNTER_BITS - 1)) - 1;
    localparam int WEAK_T_INT  = 1 << (COUNTER_BITS - 1);
    localparam logic [COUNTER_BITS-1:0] WEAK_NT     = COUNTER_BITS'(WEAK_NT_INT);
    localparam logic [COUNTER_BITS-1:0] WEAK_T      = COUNTER_BITS'(WEAK_T_INT);
    localparam logic [COUNTER_BITS-1:0] COUNTER_MAX = '1;

    logic [ENTRIES-1:0]      validBits;
    logic [TAG_BITS-1:0]     tagMem     [ENTRIES];
    logic [PC_WIDTH-1:0]     targetMem  [ENTRIES];
    logic [COUNTER_BITS-1:0] counterMem [ENTRIES];

    // Lookup path: reads only registered state, so a same-cycle update is seen one cycle later.
    logic [INDEX_BITS-1:0] lookupIndex;
    logic [TAG_BITS-1:0]   lookupTag;
    logic                  lookupHit;

    assign lookupIndex  = lookupPc[INDEX_BITS+1:2];
    assign lookupTag    = lookupPc[PC_WIDTH-1:INDEX_BITS+2];
    assign lookupHit    = validBits[lookupIndex] && (tagMem[lookupIndex] == lookupTag);
    assign predictTaken = lookupHit && counterMem[lookupIndex][COUNTER_BITS-1];
    assign predictedPc  = predictTaken ? targetMem[lookupIndex] : lookupPc + PC_WIDTH'(4);

    // Update path decode.
    logic [INDEX_BITS-1:0]   updateIndex;
    logic [TAG_BITS-1:0]     updateTag;
    logic                    updateHit;
    logic [PC_WIDTH-1:0]     storedTarget;
    logic [COUNTER_BITS-1:0] storedCounter;
    logic [COUNTER_BITS-1:0] counterNext;
    logic                    mispredicted;
    logic                    allocate;
    logic                    trainHit;

    assign updateIndex   = updatePc[INDEX_BITS+1:2];
    assign updateTag     = updatePc[PC_WIDTH-1:INDEX_BITS+2];
    assign updateHit     = validBits[updateIndex] && (tagMem[updateIndex] == updateTag);
    assign storedTarget  = targetMem[updateIndex];
    assign storedCounter = counterMem[updateIndex];

    // A flush suppresses every table write; only the valid bits are cleared that cycle.
    assign allocate = updateValid && !flush && updateTaken && !updateHit;
    assign trainHit = updateValid && !flush && updateHit;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        counterNext = storedCounter;
        if (updateTaken) begin
            if (storedCounter != COUNTER_MAX) begin
                counterNext = storedCounter + COUNTER_BITS'(1);
            end
        end else if (storedCounter != '0) begin
            counterNext = storedCounter - COUNTER_BITS'(1);
        end
    end

    always_comb begin
        mispredicted = 1'b0;
        if (updateTaken != updateWasPredictedTaken) begin
            mispredicted = 1'b1;
        end else if (updateTaken && updateHit && (storedTarget != updateTarget)) begin
            mispredicted = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            validBits <= '0;
        end else if (flush) begin
            validBits <= '0;
        end else if (allocate) begin
            validBits[updateIndex] <= 1'b1;
        end
    end

    // NOTE: the entry arrays are reset because the predictor must come up with known counters; this keeps them in flops rather than RAM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tagMem[i]     <= '0;
                targetMem[i]  <= '0;
                counterMem[i] <= WEAK_NT;
            end
        end else if (allocate) begin
            tagMem[updateIndex]     <= updateTag;
            targetMem[updateIndex]  <= updateTarget;
            counterMem[updateIndex] <= WEAK_T;
        end else if (trainHit) begin
            counterMem[updateIndex] <= counterNext;
            if (updateTaken) begin
                targetMem[updateIndex] <= updateTarget;
            end
        end
    end

    // Statistics count every accepted update, flush or not, and wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            predictionCount    <= '0;
            mispredictionCount <= '0;
        end else if (updateValid) begin
            predictionCount <= predictionCount + STAT_WIDTH'(1);
            if (mispredicted) begin
                mispredictionCount <= mispredictionCount + STAT_WIDTH'(1);
            end
        end
    end

    logic unusedPcBits;
    assign unusedPcBits = ^{lookupPc[1:0], updatePc[1:0]};

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: vector table for the training stream, hand sequences
// for flush, mid-stream reset and a small-parameter instance (1-bit counters, 4-bit statistics).
module tb_branch_target_predictor;

    logic        clock;
    logic        reset;
    logic [31:0] lookupPc;
    logic        predictTaken;
    logic [31:0] predictedPc;
    logic        updateValid;
    logic [31:0] updatePc;
    logic        updateTaken;
    logic [31:0] updateTarget;
    logic        updateWasPredictedTaken;
    logic        flush;
    logic [31:0] predictionCount;
    logic [31:0] mispredictionCount;

    logic [31:0] wLookupPc;
    logic        wPredictTaken;
    logic [31:0] wPredictedPc;
    logic        wUpdateValid;
    logic [31:0] wUpdatePc;
    logic        wUpdateTaken;
    logic [31:0] wUpdateTarget;
    logic        wUpdateWasPredictedTaken;
    logic [3:0]  wPredictionCount;
    logic [3:0]  wMispredictionCount;

    int errors = 0;
    int checks = 0;

    branch_target_predictor dut (
        .clock                  (clock),
        .reset                  (reset),
        .lookupPc               (lookupPc),
        .predictTaken           (predictTaken),
        .predictedPc            (predictedPc),
        .updateValid            (updateValid),
        .updatePc               (updatePc),
        .updateTaken            (updateTaken),
        .updateTarget           (updateTarget),
        .updateWasPredictedTaken(updateWasPredictedTaken),
        .flush                  (flush),
        .predictionCount        (predictionCount),
        .mispredictionCount     (mispredictionCount)
    );

    branch_target_predictor #(
        .PC_WIDTH    (32),
        .ENTRIES     (4),
        .COUNTER_BITS(1),
        .STAT_WIDTH  (4)
    ) dutSmall (
        .clock                  (clock),
        .reset                  (reset),
        .lookupPc               (wLookupPc),
        .predictTaken           (wPredictTaken),
        .predictedPc            (wPredictedPc),
        .updateValid            (wUpdateValid),
        .updatePc               (wUpdatePc),
        .updateTaken            (wUpdateTaken),
        .updateTarget           (wUpdateTarget),
        .updateWasPredictedTaken(wUpdateWasPredictedTaken),
        .flush                  (1'b0),
        .predictionCount        (wPredictionCount),
        .mispredictionCount     (wMispredictionCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        uValid;
        logic [31:0] uPc;
        logic        uTaken;
        logic [31:0] uTarget;
        logic        uWas;
        logic [31:0] lPc;
        logic        eTaken;
        logic [31:0] ePc;
        int          ePred;
        int          eMis;
    } vec_t;

    localparam int NUM_VECS = 21;
    vec_t vecs [NUM_VECS];

    function automatic vec_t mk(input logic uValid, input logic [31:0] uPc, input logic uTaken,
                                input logic [31:0] uTarget, input logic uWas, input logic [31:0] lPc,
                                input logic eTaken, input logic [31:0] ePc, input int ePred,
                                input int eMis);
        vec_t v;
        v.uValid = uValid; v.uPc = uPc; v.uTaken = uTaken; v.uTarget = uTarget; v.uWas = uWas;
        v.lPc = lPc; v.eTaken = eTaken; v.ePc = ePc; v.ePred = ePred; v.eMis = eMis;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkMain(input string name, input logic eTaken, input logic [31:0] ePc,
                             input int ePred, input int eMis);
        check({name, ".predictTaken"}, 64'(predictTaken), 64'(eTaken));
        check({name, ".predictedPc"}, 64'(predictedPc), 64'(ePc));
        check({name, ".predictionCount"}, 64'(predictionCount), 64'(ePred));
        check({name, ".mispredictionCount"}, 64'(mispredictionCount), 64'(eMis));
    endtask

    task automatic smallUpdate(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                               input logic was);
        wUpdateValid = 1'b1; wUpdatePc = pc; wUpdateTaken = taken;
        wUpdateTarget = target; wUpdateWasPredictedTaken = was;
        step();
        wUpdateValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        // Lookup is checked before the edge, so it reflects the state left by earlier rows.
        vecs[0]  = mk(0, 32'h0,    0, 32'h0,   0, 32'h40,       0, 32'h44,    0, 0);
        vecs[1]  = mk(1, 32'h40,   1, 32'h100, 0, 32'h40,       0, 32'h44,    0, 0);
        vecs[2]  = mk(0, 32'h0,    0, 32'h0,   0, 32'h40,       1, 32'h100,   1, 1);
        vecs[3]  = mk(1, 32'h40,   0, 32'h0,   1, 32'h40,       1, 32'h100,   1, 1);
        vecs[4]  = mk(1, 32'h40,   0, 32'h0,   0, 32'h40,       0, 32'h44,    2, 2);
        vecs[5]  = mk(1, 32'h40,   0, 32'h0,   0, 32'h40,       0, 32'h44,    3, 2);
        vecs[6]  = mk(1, 32'h40,   1, 32'h100, 0, 32'h40,       0, 32'h44,    4, 2);
        vecs[7]  = mk(1, 32'h40,   1, 32'h100, 0, 32'h40,       0, 32'h44,    5, 3);
        vecs[8]  = mk(1, 32'h40,   1, 32'h100, 1, 32'h40,       1, 32'h100,   6, 4);
        vecs[9]  = mk(1, 32'h40,   1, 32'h100, 1, 32'h40,       1, 32'h100,   7, 4);
        vecs[10] = mk(1, 32'h40,   0, 32'h0,   1, 32'h40,       1, 32'h100,   8, 4);
        vecs[11] = mk(0, 32'h0,    0, 32'h0,   0, 32'h40,       1, 32'h100,   9, 5);
        vecs[12] = mk(1, 32'h40,   1, 32'h180, 1, 32'h40,       1, 32'h100,   9, 5);
        vecs[13] = mk(0, 32'h0,    0, 32'h0,   0, 32'h40,       1, 32'h180,  10, 6);
        vecs[14] = mk(1, 32'h440,  1, 32'h200, 0, 32'h440,      0, 32'h444,  10, 6);
        vecs[15] = mk(0, 32'h0,    0, 32'h0,   0, 32'h40,       0, 32'h44,   11, 7);
        vecs[16] = mk(0, 32'h0,    0, 32'h0,   0, 32'h440,      1, 32'h200,  11, 7);
        vecs[17] = mk(1, 32'h80,   0, 32'h0,   0, 32'h440,      1, 32'h200,  11, 7);
        vecs[18] = mk(0, 32'h0,    0, 32'h0,   0, 32'h440,      1, 32'h200,  12, 7);
        vecs[19] = mk(0, 32'h0,    0, 32'h0,   0, 32'h443,      1, 32'h200,  12, 7);
        vecs[20] = mk(0, 32'h0,    0, 32'h0,   0, 32'hFFFFFFFC, 0, 32'h0,    12, 7);

        reset = 1'b0; flush = 1'b0;
        lookupPc = 32'h40; updateValid = 1'b0; updatePc = '0; updateTaken = 1'b0;
        updateTarget = '0; updateWasPredictedTaken = 1'b0;
        wLookupPc = 32'h40; wUpdateValid = 1'b0; wUpdatePc = '0; wUpdateTaken = 1'b0;
        wUpdateTarget = '0; wUpdateWasPredictedTaken = 1'b0;
        step();
        step();
        reset = 1'b1;

        for (int i = 0; i < NUM_VECS; i++) begin
            updateValid = vecs[i].uValid; updatePc = vecs[i].uPc; updateTaken = vecs[i].uTaken;
            updateTarget = vecs[i].uTarget; updateWasPredictedTaken = vecs[i].uWas;
            lookupPc = vecs[i].lPc;
            #2;
            checkMain($sformatf("vec%0d", i), vecs[i].eTaken, vecs[i].ePc, vecs[i].ePred, vecs[i].eMis);
            step();
        end
        updateValid = 1'b0;

        // Flush together with a would-be allocation: valid bits clear, no allocation, stats count it.
        flush = 1'b1; updateValid = 1'b1; updatePc = 32'h84; updateTaken = 1'b1;
        updateTarget = 32'h300; updateWasPredictedTaken = 1'b0;
        step();
        flush = 1'b0; updateValid = 1'b0;
        lookupPc = 32'h440; #1;
        checkMain("flush.alias", 1'b0, 32'h444, 13, 8);
        lookupPc = 32'h84; #1;
        checkMain("flush.noAlloc", 1'b0, 32'h88, 13, 8);

        updateValid = 1'b1; updatePc = 32'h440; updateTaken = 1'b1;
        updateTarget = 32'h240; updateWasPredictedTaken = 1'b0;
        step();
        updateValid = 1'b0;
        lookupPc = 32'h440; #1;
        checkMain("realloc", 1'b1, 32'h240, 14, 9);

        // Reset mid-stream: outputs must return to reset values with no clock edge.
        #2;
        reset = 1'b0;
        #1;
        checkMain("asyncReset", 1'b0, 32'h444, 0, 0);

        // An update presented while reset is held is ignored.
        updateValid = 1'b1; updatePc = 32'h440; updateTaken = 1'b1;
        updateTarget = 32'h500; updateWasPredictedTaken = 1'b0;
        step();
        updateValid = 1'b0;
        reset = 1'b1;
        #1;
        checkMain("updateInReset", 1'b0, 32'h444, 0, 0);
        step();
        #1;
        checkMain("afterRelease", 1'b0, 32'h444, 0, 0);

        // Small instance: 1-bit counters and wrapping 4-bit statistics.
        smallUpdate(32'h40, 1'b1, 32'h100, 1'b0);
        #1;
        check("small.allocTaken", 64'(wPredictTaken), 64'd1);
        check("small.allocPc", 64'(wPredictedPc), 64'h100);
        smallUpdate(32'h40, 1'b0, 32'h0, 1'b1);
        #1;
        check("small.ntTaken", 64'(wPredictTaken), 64'd0);
        check("small.ntPc", 64'(wPredictedPc), 64'h44);
        check("small.count2", 64'(wPredictionCount), 64'd2);
        check("small.mis2", 64'(wMispredictionCount), 64'd2);
        for (int i = 0; i < 14; i++) begin
            smallUpdate(32'h40, 1'b0, 32'h0, 1'b0);
        end
        #1;
        check("small.wrapCount", 64'(wPredictionCount), 64'd0);
        check("small.wrapMis", 64'(wMispredictionCount), 64'd2);
        smallUpdate(32'h40, 1'b0, 32'h0, 1'b0);
        #1;
        check("small.afterWrap", 64'(wPredictionCount), 64'd1);
        check("small.satZero", 64'(wPredictTaken), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
